nios_qsys_onchip_memory_pipe: RTL

NIOS_QSYS_ONCHIP_MEMORY_PIPE -- requirements
Module: nios_qsys_onchip_memory_pipe

---
 rtl/nios_qsys_onchip_memory_pipe.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/nios_qsys_onchip_memory_pipe.sv
// On-chip single-port RAM slave with a 1- or 2-stage read pipeline and clock enable.
// Latency: readdata/readdatavalid READ_LATENCY enabled cycles after an accepted read.
// Backpressure: waitrequest = reset_req | ~clken; optional per-byte parity via ONCHIP_MEM_PARITY_EN.
module nios_qsys_onchip_memory_pipe #(
    parameter int    DATA_W       = 32,
    parameter int    ADDR_W       = 11,
    parameter int    DEPTH        = 2048,
    parameter int    READ_LATENCY = 1,
    parameter string INIT_FILE    = ""
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  reset_req,
    input  logic                  clken,
    input  logic                  chipselect,
    input  logic                  read,
    input  logic                  write,
    input  logic [ADDR_W-1:0]     address,
    input  logic [DATA_W/8-1:0]   byteenable,
    input  logic [DATA_W-1:0]     writedata,
    output logic                  waitrequest,
    output logic [DATA_W-1:0]     readdata,
    output logic                  readdatavalid,
    output logic                  parity_error
);

    localparam int BYTES = DATA_W / 8;
`ifdef ONCHIP_MEM_PARITY_EN
    localparam int PW = BYTES;
`else
    localparam int PW = 0;
`endif
    // Pipeline word carries data plus (when enabled) its stored parity bits.
    localparam int WW = DATA_W + PW;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    logic              accept;
    logic              wr_acc;
    logic              rd_acc;
    logic              in_range;
    logic [DATA_W-1:0] ram_rdata;
    logic [WW-1:0]     ram_word;

    logic [WW-1:0]     s1_word;
    logic              s1_vld;
    logic [WW-1:0]     out_word;
    logic              out_vld;

    assign waitrequest = reset_req | ~clken;
    assign accept      = chipselect & (read | write) & ~waitrequest;
    assign wr_acc      = accept & write;
    // A combined read+write behaves as a write only.
    assign rd_acc      = accept & read & ~write;
    assign in_range    = {1'b0, address} < DEPTH_L;
    // Out-of-range reads return zero but still produce a normal valid.
    assign ram_rdata   = in_range ? mem[address] : '0;

    // RAM write port: byte-enabled, out-of-range writes dropped; no reset so contents survive it.
    always_ff @(posedge clk) begin
        if (wr_acc && in_range) begin
            for (int b = 0; b < BYTES; b++) begin
                if (byteenable[b]) mem[address][b*8 +: 8] <= writedata[b*8 +: 8];
            end
        end
    end

`ifdef ONCHIP_MEM_PARITY_EN
    logic [BYTES-1:0] par_mem [0:DEPTH-1];
    logic [BYTES-1:0] ram_rpar;
    logic [BYTES-1:0] out_par_calc;
    logic             par_mismatch;

    assign ram_rpar = in_range ? par_mem[address] : '0;
    assign ram_word = {ram_rpar, ram_rdata};

    // Even-parity bit per byte, written together with that byte.
    always_ff @(posedge clk) begin
        if (wr_acc && in_range) begin
            for (int b = 0; b < BYTES; b++) begin
                if (byteenable[b]) par_mem[address][b] <= ^writedata[b*8 +: 8];
            end
        end
    end

    always_comb begin
        out_par_calc = '0;
        for (int b = 0; b < BYTES; b++) out_par_calc[b] = ^out_word[b*8 +: 8];
    end
    assign par_mismatch = |(out_par_calc ^ out_word[WW-1:DATA_W]);

    // Sticky error: any byte mismatch on a delivered word latches until reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                              parity_error <= 1'b0;
        else if (readdatavalid && par_mismatch) parity_error <= 1'b1;
    end
`else
    assign ram_word     = ram_rdata;
    assign parity_error = 1'b0;
`endif

    // First read stage: capture RAM output; data only reloads on a read so readdata holds otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_vld  <= 1'b0;
            s1_word <= '0;
        end else if (clken) begin
            s1_vld <= rd_acc;
            if (rd_acc) s1_word <= ram_word;
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic [WW-1:0] s2_word;
            logic          s2_vld;

            // Extra output register stage, frozen with clken like the rest of the pipe.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    s2_vld  <= 1'b0;
                    s2_word <= '0;
                end else if (clken) begin
                    s2_vld <= s1_vld;
                    if (s1_vld) s2_word <= s1_word;
                end
            end

            assign out_word = s2_word;
            assign out_vld  = s2_vld;
        end else begin : g_lat1
            assign out_word = s1_word;
            assign out_vld  = s1_vld;
        end
    endgenerate

    // A stalled pipe never presents valid; the held bit reappears once clken returns.
    assign readdatavalid = out_vld & clken;
    assign readdata      = out_word[DATA_W-1:0];

endmodule
